// File: rtl/digit_scan_mux.sv
// rtl/digit_scan_mux.sv - multiplexed BCD display scanner feeding a 7-segment decoder
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   load, digits_in  capture request and packed BCD frame (nibble i = digit i)
//   ready            pending buffer empty, a load will be accepted
//   bcd              digit currently presented to the decoder
//   dec_valid        decoder's valid flag for bcd (combinational return)
//   an               one-hot active-high digit enable, all-zero = dark
//   blank            current slot is blanked (leading zero)
//   digit_idx        index of the current slot
//   err, err_clr     sticky invalid-digit flag and its clear

module digit_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_WIDTH  = 16,
    parameter int BLANK_LZ   = 1,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic                    ready,
    output logic [3:0]              bcd,
    input  logic                    dec_valid,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    blank,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    err,
    input  logic                    err_clr
);

    logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_full_q, pend_full_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    err_q, err_d;

    logic                    tick;
    logic                    wrap;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              bcd_sel;
    logic                    blank_sel;

    always_comb begin
        tick = (cnt_q == DIV_WIDTH'(SCAN_DIV - 1));
        wrap = (idx_q == IDX_W'(NUM_DIGITS - 1));

        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        an_d        = an_q;
        err_d       = err_q;

        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        // Frame transfer needs pending full, a load needs it empty, so the
        // two never compete; the transfer always carries the older frame.
        if (tick && wrap && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end else if (load && !pend_full_q) begin
            pending_d   = digits_in;
            pend_full_d = 1'b1;
        end

        // Walk from the most significant digit down; a digit is a leading
        // zero while everything above it (and itself) is zero.
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero && (active_d[4*i +: 4] == 4'd0);
            blank_vec[i] = (BLANK_LZ != 0) && (i > 0) && upper_zero;
        end

        // Slot contents are taken from the post-transfer frame so the first
        // slot of a new frame already shows new data.
        bcd_sel   = '0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                bcd_sel   = active_d[4*i +: 4];
                blank_sel = blank_vec[i];
            end
        end

        if (tick) begin
            bcd_d   = bcd_sel;
            blank_d = blank_sel;
            an_d    = '0;               // dead cycle while bcd settles
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = !blank_q && (IDX_W'(i) == idx_q);
            end
        end

        // Only a lit slot can flag an error; set beats clear.
        if ((an_q != '0) && !dec_valid) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= 1'b0;
            an_q        <= NUM_DIGITS'(1);
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            an_q        <= an_d;
            err_q       <= err_d;
        end
    end

    assign ready     = !pend_full_q;
    assign bcd       = bcd_q;
    assign an        = an_q;
    assign blank     = blank_q;
    assign digit_idx = idx_q;
    assign err       = err_q;

endmodule
